// File: rtl/dpsram_store_buffer.sv
// Byte-masked store queue in front of a dpsram write port, with read-after-write forwarding to port A.
// Optional push coalescing into the youngest entry when DPSRAM_SB_COALESCE_EN is defined.
module dpsram_store_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_DEPTH  = 1024,
  parameter int BYTE_SIZE   = 8,
  parameter int QUEUE_DEPTH = 4,
  localparam int AW = $clog2(DATA_DEPTH),
  localparam int NB = DATA_WIDTH / BYTE_SIZE,
  localparam int QW = $clog2(QUEUE_DEPTH),
  localparam int CW = QW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [AW-1:0]         push_addr_i,
  input  logic [NB-1:0]         push_we_i,
  input  logic [DATA_WIDTH-1:0] push_wdata_i,
  input  logic                  sram_gnt_i,
  output logic                  sram_en_o,
  output logic [NB-1:0]         sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic                  fwd_en_i,
  input  logic [AW-1:0]         fwd_addr_i,
  output logic [NB-1:0]         fwd_hit_o,
  output logic [DATA_WIDTH-1:0] fwd_data_o,
  output logic [CW-1:0]         count_o,
  output logic                  empty_o
);

  logic [AW-1:0]         r_addr [QUEUE_DEPTH];
  logic [NB-1:0]         r_mask [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] r_data [QUEUE_DEPTH];
  logic [QW:0]           r_wptr, r_rptr;
  logic [NB-1:0]         r_fwd_hit;
  logic [DATA_WIDTH-1:0] r_fwd_data;

  logic [CW-1:0]         w_count;
  logic                  w_empty, w_full, w_pop;
  logic [QW-1:0]         w_head, w_tail, w_young;
  logic                  w_merge_ok, w_accept, w_alloc, w_merge;
  logic [NB-1:0]         w_fwd_hit;
  logic [DATA_WIDTH-1:0] w_fwd_data;

  assign w_head  = r_rptr[QW-1:0];
  assign w_tail  = r_wptr[QW-1:0];
  assign w_young = w_tail - QW'(1);
  assign w_count = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[QW-1:0] == r_rptr[QW-1:0]) && (r_wptr[QW] != r_rptr[QW]);
  assign w_pop   = !w_empty && sram_gnt_i;

`ifdef DPSRAM_SB_COALESCE_EN
  // The youngest entry cannot absorb a push on the edge it leaves the queue.
  assign w_merge_ok = !w_empty && (r_addr[w_young] == push_addr_i) &&
                      !(w_pop && (w_young == w_head));
`else
  assign w_merge_ok = 1'b0;
`endif

  assign push_ready_o = !w_full || w_merge_ok;
  assign w_accept     = push_valid_i && push_ready_o && (|push_we_i);
  assign w_alloc      = w_accept && !w_merge_ok;
  assign w_merge      = w_accept && w_merge_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_alloc) r_wptr <= r_wptr + (QW+1)'(1);
      if (w_pop)   r_rptr <= r_rptr + (QW+1)'(1);
    end
  end

  // Payload needs no reset; validity is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[w_tail] <= push_addr_i;
      r_mask[w_tail] <= push_we_i;
      r_data[w_tail] <= push_wdata_i;
    end else if (w_merge) begin
      r_mask[w_young] <= r_mask[w_young] | push_we_i;
      for (int b = 0; b < NB; b++) begin
        if (push_we_i[b])
          r_data[w_young][b*BYTE_SIZE +: BYTE_SIZE] <= push_wdata_i[b*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

  assign sram_en_o    = w_pop;
  assign sram_we_o    = w_pop ? r_mask[w_head] : '0;
  assign sram_addr_o  = r_addr[w_head];
  assign sram_wdata_o = r_data[w_head];

  // Walk oldest to youngest so the youngest matching lane overwrites older ones.
  always_comb begin
    w_fwd_hit  = '0;
    w_fwd_data = '0;
    for (int k = 0; k < QUEUE_DEPTH; k++) begin
      if ((CW'(k) < w_count) && (r_addr[w_head + QW'(k)] == fwd_addr_i)) begin
        for (int b = 0; b < NB; b++) begin
          if (r_mask[w_head + QW'(k)][b]) begin
            w_fwd_hit[b] = 1'b1;
            w_fwd_data[b*BYTE_SIZE +: BYTE_SIZE] =
              r_data[w_head + QW'(k)][b*BYTE_SIZE +: BYTE_SIZE];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_hit  <= '0;
      r_fwd_data <= '0;
    end else if (fwd_en_i) begin
      r_fwd_hit  <= w_fwd_hit;
      r_fwd_data <= w_fwd_data;
    end else begin
      r_fwd_hit  <= '0;
      r_fwd_data <= '0;
    end
  end

  assign fwd_hit_o  = r_fwd_hit;
  assign fwd_data_o = r_fwd_data;
  assign count_o    = w_count;
  assign empty_o    = w_empty;

endmodule

// File: tb/tb_dpsram_store_buffer.sv
// Bench for dpsram_store_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_dpsram_store_buffer;

  localparam int DW = 32;
  localparam int QD = 4;
  localparam int AW = 10;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push_valid = 1'b0;
  logic          push_ready_o;
  logic [AW-1:0] push_addr = '0;
  logic [NB-1:0] push_we = '0;
  logic [DW-1:0] push_wdata = '0;
  logic          gnt = 1'b0;
  logic          sram_en_o;
  logic [NB-1:0] sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic          fwd_en = 1'b0;
  logic [AW-1:0] fwd_addr = '0;
  logic [NB-1:0] fwd_hit_o;
  logic [DW-1:0] fwd_data_o;
  logic [2:0]    count_o;
  logic          empty_o;

  typedef struct {
    logic [AW-1:0] addr;
    logic [NB-1:0] mask;
    logic [DW-1:0] data;
  } ent_t;

  ent_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  dpsram_store_buffer #(.DATA_WIDTH(DW), .DATA_DEPTH(1024), .BYTE_SIZE(8), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .push_valid_i(push_valid), .push_ready_o(push_ready_o), .push_addr_i(push_addr),
    .push_we_i(push_we), .push_wdata_i(push_wdata),
    .sram_gnt_i(gnt), .sram_en_o(sram_en_o), .sram_we_o(sram_we_o),
    .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
    .fwd_en_i(fwd_en), .fwd_addr_i(fwd_addr), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
    .count_o(count_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs against the model, advance the model, check forwarding.
  task automatic cyc();
    bit pop, merge, ready;
    logic [NB-1:0] eh;
    logic [DW-1:0] ed;
    ent_t e;
    #1;
    pop   = (q.size() > 0) && gnt;
    merge = 1'b0;
`ifdef DPSRAM_SB_COALESCE_EN
    merge = (q.size() > 0) && (q[q.size()-1].addr == push_addr) && !(pop && q.size() == 1);
`endif
    ready = (q.size() < QD) || merge;
    chk("push_ready", push_ready_o, ready);
    chk("count", count_o, q.size());
    chk("empty", empty_o, q.size() == 0);
    chk("sram_en", sram_en_o, pop);
    chk("sram_we", sram_we_o, pop ? q[0].mask : 4'h0);
    if (pop) begin
      chk("sram_addr", sram_addr_o, q[0].addr);
      chk("sram_wdata", sram_wdata_o, q[0].data);
    end
    eh = '0;
    ed = '0;
    if (fwd_en) begin
      foreach (q[k]) begin
        if (q[k].addr == fwd_addr) begin
          for (int b = 0; b < NB; b++) begin
            if (q[k].mask[b]) begin
              eh[b] = 1'b1;
              ed[b*8 +: 8] = q[k].data[b*8 +: 8];
            end
          end
        end
      end
    end
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push_valid && ready && push_we != 0) begin
      if (merge) begin
        e = q[q.size()-1];
        e.mask = e.mask | push_we;
        for (int b = 0; b < NB; b++)
          if (push_we[b]) e.data[b*8 +: 8] = push_wdata[b*8 +: 8];
        q[q.size()-1] = e;
      end else begin
        e.addr = push_addr;
        e.mask = push_we;
        e.data = push_wdata;
        q.push_back(e);
      end
    end
    #1;
    chk("fwd_hit", fwd_hit_o, eh);
    chk("fwd_data", fwd_data_o, ed);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    push_valid = 1'b0;
    push_we    = '0;
    fwd_en     = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [NB-1:0] we, input logic [DW-1:0] d);
    push_valid = 1'b1;
    push_addr  = a;
    push_we    = we;
    push_wdata = d;
    cyc();
    idle_inputs();
  endtask

  task automatic drain();
    idle_inputs();
    gnt = 1'b1;
    for (int i = 0; i < 2*QD && q.size() > 0; i++) cyc();
    chk("drained_empty", empty_o, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_sram_en", sram_en_o, 1'b0);
    chk("rst_sram_we", sram_we_o, 4'h0);
    chk("rst_count", count_o, 3'd0);
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_ready", push_ready_o, 1'b1);
    chk("rst_fwd_hit", fwd_hit_o, 4'h0);
    chk("rst_fwd_data", fwd_data_o, 32'h0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Fill with no grant, then drain in order
    gnt = 1'b0;
    for (int i = 0; i < 4; i++) push(10'h10 + 10'(i), 4'hF, $urandom);
    push(10'h14, 4'hF, 32'h12345678);
    chk("full_ready", push_ready_o, 1'b0);
    chk("full_count", count_o, 3'd4);
    gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fill_drain_addr", sram_addr_o, 10'h10 + 10'(i));
      chk("fill_drain_we", sram_we_o, 4'hF);
      cyc();
    end
    chk("fill_drain_empty", empty_o, 1'b1);

    // Overlapping masked stores to one address, read back through the forward path
    gnt = 1'b0;
    push(10'h20, 4'b0011, 32'hAABBCCDD);
    push(10'h20, 4'b0110, 32'h11223344);
    fwd_en = 1'b1;
    fwd_addr = 10'h20;
    cyc();
    chk("fwd_two_hit", fwd_hit_o, 4'b0111);
    chk("fwd_two_data", fwd_data_o, 32'h002233DD);
    drain();

    // Forward from the entry being written on the same edge
    gnt = 1'b0;
    push(10'h30, 4'hF, 32'hDEADBEEF);
    gnt = 1'b1;
    fwd_en = 1'b1;
    fwd_addr = 10'h30;
    cyc();
    chk("fwd_drain_hit", fwd_hit_o, 4'hF);
    chk("fwd_drain_data", fwd_data_o, 32'hDEADBEEF);
    idle_inputs();

    // Full with a pop: push refused, then accepted alongside the next pop
    gnt = 1'b0;
    for (int i = 0; i < 4; i++) push(10'h50 + 10'(i), 4'hF, $urandom);
    gnt = 1'b1;
    push(10'h54, 4'hF, 32'h54545454);
    chk("full_pop_count", count_o, 3'd3);
    push(10'h55, 4'hF, 32'h55555555);
    chk("push_pop_count", count_o, 3'd3);
    drain();

    // Reset while draining
    gnt = 1'b0;
    for (int i = 0; i < 3; i++) push(10'h60 + 10'(i), 4'hF, $urandom);
    gnt = 1'b1;
    fwd_en = 1'b1;
    fwd_addr = 10'h60;
    cyc();
    do_reset();
    idle_inputs();
    gnt = 1'b0;
    cyc();

    // Two partial stores to the same word
    push(10'h40, 4'b0001, 32'h000000A1);
    push(10'h40, 4'b1000, 32'hB2000000);
`ifdef DPSRAM_SB_COALESCE_EN
    chk("coalesce_count", count_o, 3'd1);
    gnt = 1'b1;
    #1;
    chk("coalesce_we", sram_we_o, 4'b1001);
    chk("coalesce_wdata", sram_wdata_o[31:24], 8'hB2);
`else
    chk("no_coalesce_count", count_o, 3'd2);
    gnt = 1'b1;
    #1;
    chk("no_coalesce_we", sram_we_o, 4'b0001);
`endif
    drain();

    // Random traffic over a small address window so forwarding and merging get exercised
    for (int i = 0; i < 600; i++) begin
      push_valid = ($urandom_range(0, 3) != 0);
      push_addr  = 10'h70 + 10'($urandom_range(0, 3));
      push_we    = 4'($urandom_range(0, 15));
      push_wdata = $urandom;
      gnt        = ($urandom_range(0, 2) == 0);
      fwd_en     = ($urandom_range(0, 1) == 1);
      fwd_addr   = 10'h70 + 10'($urandom_range(0, 4));
      cyc();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
